// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampling-counter framing, optional parity, and a
// show-ahead receive FIFO with sticky frame/parity/overrun error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 2170,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk_250mhz,
  input  logic                              reset_n,
  input  logic                              uart_rx,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overrun_err,
  input  logic                              err_clear
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t               state;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_idx;
  logic [1:0]           stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, par_bad, stop_bad;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 tick, frame_done, fe_set, pe_set, ov_set, good_frame;
  logic                 full, pop, push;

  assign tick       = (clk_cnt == '0);
  assign frame_done = (state == STOP) && tick && (stop_idx == 2'(STOP_BITS-1));
  assign fe_set     = frame_done && (stop_bad || !rx_s);
  assign pe_set     = frame_done && !fe_set && par_bad;
  assign good_frame = frame_done && !fe_set && !par_bad;
  assign full       = (fifo_count == NW'(FIFO_DEPTH));
  assign rx_valid   = (fifo_count != '0);
  assign pop        = rx_valid && rx_ready;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push       = good_frame && (!full || pop);
  assign ov_set     = good_frame && !push;
  assign rx_data    = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_250mhz or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_250mhz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!rx_s) begin
          state   <= START;
          clk_cnt <= CW'(CLKS_PER_BIT/2);
        end
        START: begin
          if (!tick) clk_cnt <= clk_cnt - CW'(1);
          else if (rx_s) state <= IDLE;
          else begin
            state    <= DATA;
            clk_cnt  <= CW'(CLKS_PER_BIT-1);
            bit_idx  <= '0;
            stop_idx <= '0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
          end
        end
        DATA: begin
          if (!tick) clk_cnt <= clk_cnt - CW'(1);
          else begin
            clk_cnt <= CW'(CLKS_PER_BIT-1);
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ rx_s;
            if (bit_idx == 4'(DATA_BITS-1)) state <= (PARITY_EN != 0) ? PARITY : STOP;
            else bit_idx <= bit_idx + 4'd1;
          end
        end
        PARITY: begin
          if (!tick) clk_cnt <= clk_cnt - CW'(1);
          else begin
            clk_cnt <= CW'(CLKS_PER_BIT-1);
            par_bad <= par_acc ^ rx_s ^ PARITY_ODD[0];
            state   <= STOP;
          end
        end
        STOP: begin
          if (!tick) clk_cnt <= clk_cnt - CW'(1);
          else if (frame_done) state <= fe_set ? WAIT_IDLE : IDLE;
          else begin
            clk_cnt  <= CW'(CLKS_PER_BIT-1);
            stop_bad <= stop_bad | ~rx_s;
            stop_idx <= stop_idx + 2'd1;
          end
        end
        // A held-low line (break) must not retrigger a new frame.
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_250mhz) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_250mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + NW'(1);
        2'b01:   fifo_count <= fifo_count - NW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky flags: a same-cycle set beats err_clear.
  always_ff @(posedge clk_250mhz or negedge reset_n) begin
    if (!reset_n) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= fe_set | (frame_err   & ~err_clear);
      parity_err  <= pe_set | (parity_err  & ~err_clear);
      overrun_err <= ov_set | (overrun_err & ~err_clear);
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 2170, clock cycles per bit (250 MHz / 115200 baud), legal range 8 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5 to 9.
REQ-003 SHALL have parameter PARITY_EN, default 0, where 1 means a parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, where 1 means odd parity and 0 means even parity (used only when PARITY_EN=1).
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries, a power of 2 of at least 2.
REQ-007 SHALL have port clk_250mhz, input, 1 bit: single clock, all state on its rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port uart_rx, input, 1 bit: asynchronous serial line that idles high.
REQ-010 SHALL have port rx_data, output, DATA_BITS wide: FIFO head word.
REQ-011 SHALL have port rx_valid, output, 1 bit: FIFO not empty.
REQ-012 SHALL have port rx_ready, input, 1 bit: consumer accepts the head word.
REQ-013 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1) bits: current occupancy.
REQ-014 SHALL have port frame_err, output, 1 bit: sticky flag, a stop bit was sampled low.
REQ-015 SHALL have port parity_err, output, 1 bit: sticky flag, parity mismatch.
REQ-016 SHALL have port overrun_err, output, 1 bit: sticky flag, a good frame was dropped because the FIFO was full.
REQ-017 SHALL have port err_clear, input, 1 bit: single-cycle pulse that clears all three sticky flags.

Function
REQ-018 SHALL pass uart_rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-020 SHALL move from IDLE to START on the first cycle rx_s=0 and load the bit counter with CLKS_PER_BIT/2 (floor).
REQ-021 SHALL, in START at mid-bit, go to DATA if rx_s=0, else return to IDLE as a glitch with no flag set.
REQ-022 SHALL, in DATA, sample every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples.
REQ-023 SHALL then go to PARITY if PARITY_EN=1, else to STOP.
REQ-024 SHALL, in PARITY, sample one bit; mismatch means XOR(data, parity bit) != PARITY_ODD.
REQ-025 SHALL, in STOP, sample STOP_BITS bits; any low stop sample is a framing error.
REQ-026 SHALL evaluate the frame at the final stop sample:
- framing error: set frame_err, discard the byte, go to WAIT_IDLE.
- else parity error: set parity_err, discard the byte, go to IDLE.
- else FIFO accepts the push (REQ-029): push the byte, go to IDLE.
- else: set overrun_err, drop the byte, go to IDLE.
REQ-027 SHALL remain in WAIT_IDLE until rx_s=1, then go to IDLE, so a break condition yields exactly one frame_err event.
REQ-028 SHALL present rx_data as show-ahead: rx_valid=1 whenever fifo_count>0, pop when rx_valid and rx_ready are both 1, and hold rx_data stable while rx_valid=1 and rx_ready=0.
REQ-029 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle; a simultaneous push and pop leaves fifo_count unchanged.
REQ-030 SHALL ignore rx_ready while the FIFO is empty, with no underflow and no count change.
REQ-031 SHALL use read/write pointers that wrap modulo FIFO_DEPTH.
REQ-032 SHALL assert rx_valid the cycle after the push cycle when the FIFO was empty.
REQ-033 SHALL give err_clear priority over a same-cycle set only for flags not being set that cycle; a same-cycle set wins.
REQ-034 SHALL drop a frame in progress when reset is asserted mid-frame, and SHALL not push a partial byte.

Reset
REQ-035 SHALL, while reset_n=0, asynchronously force:
- FSM to IDLE;
- synchronizer flops to 1;
- pointers and fifo_count to 0;
- rx_valid=0, rx_data=0;
- frame_err=0, parity_err=0, overrun_err=0.
REQ-036 SHALL deassert reset synchronously at the design's top level; this block requires no extra idle cycles after reset.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4 unless noted)
REQ-037 SHALL cover this scenario: send 0xA5 (8N1) with rx_ready=0 -> rx_valid=1, rx_data=0xA5, fifo_count=1, no flags set.
REQ-038 SHALL cover this scenario: send 5 frames 0x01 to 0x05 with rx_ready=0 -> fifo_count=4, overrun_err=1; then pop 4 -> 0x01, 0x02, 0x03, 0x04.
REQ-039 SHALL cover this scenario: PARITY_EN=1, PARITY_ODD=0, send 0x03 with parity bit 1 -> parity_err=1, fifo_count=0; err_clear pulse -> parity_err=0.
REQ-040 SHALL cover this scenario: hold uart_rx=0 for 40 bit times, then release -> exactly one frame_err, fifo_count=0; next 0x5A is received correctly.
REQ-041 SHALL cover this scenario: send a 4-cycle low glitch on idle uart_rx -> no frame received, no flags; assert reset_n=0 mid-frame -> all outputs 0, and the next frame is received intact.
REQ-042 SHALL cover this scenario: full FIFO with rx_ready=1 in the same cycle a stop bit completes -> byte accepted, fifo_count stays 4, overrun_err=0.
